// File: rtl/instr_mem_loader_if.sv
// Byte-stream load channel: an image source (master) pushes bytes into the loader (slave).
interface instr_mem_loader_if;
   logic       load_valid_i;
   logic [7:0] load_data_i;
   logic       load_last_i;
   logic       load_ready_o;

   modport master (
      output load_valid_i,
      output load_data_i,
      output load_last_i,
      input  load_ready_o
   );

   modport slave (
      input  load_valid_i,
      input  load_data_i,
      input  load_last_i,
      output load_ready_o
   );
endinterface

// File: rtl/instr_mem_loader.sv
// Boot loader: assembles a little-endian byte stream into instruction RAM, then
// releases the CPU and serves fetches; overflow of the RAM parks it in a sticky error.
module instr_mem_loader #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DAT_WIDTH   = 32,
   parameter int DEPTH_WORDS = 256
) (
   input  logic                         clk,
   input  logic                         rst_n,
   instr_mem_loader_if.slave            load,
   input  logic                         reload_i,
   input  logic [ADDR_WIDTH-1:0]        pc_i,
   output logic [DAT_WIDTH-1:0]         instr_o,
   output logic                         cpu_rst_n_o,
   output logic                         load_done_o,
   output logic                         load_err_o,
   output logic [$clog2(DEPTH_WORDS):0] word_count_o
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int WC_W  = IDX_W + 1;
   localparam logic [DAT_WIDTH-1:0] NOP = DAT_WIDTH'(32'h0000_0013);

   typedef enum logic [1:0] {LOAD, RUN, ERROR} state_t;

   state_t               state;
   logic [1:0]           byte_cnt;
   logic [23:0]          part_word;
   logic                 load_ready;
   logic [DAT_WIDTH-1:0] ram [DEPTH_WORDS];

   logic                  accept;
   logic                  full;
   logic                  wr_en;
   logic [31:0]           asm_word;
   logic [ADDR_WIDTH-1:0] pc_word;

   assign accept = load.load_valid_i && load_ready;
   assign full   = (word_count_o == WC_W'(DEPTH_WORDS));
   assign wr_en  = accept && !full && ((byte_cnt == 2'd3) || load.load_last_i);
   assign load.load_ready_o = load_ready;

   // Lanes above the incoming byte stay zero so a short final word is zero-padded.
   always_comb begin
      asm_word = 32'h0;
      case (byte_cnt)
         2'd0:    asm_word = {24'h0, load.load_data_i};
         2'd1:    asm_word = {16'h0, load.load_data_i, part_word[7:0]};
         2'd2:    asm_word = {8'h0,  load.load_data_i, part_word[15:0]};
         default: asm_word = {load.load_data_i, part_word[23:0]};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= LOAD;
         byte_cnt     <= 2'd0;
         word_count_o <= '0;
         cpu_rst_n_o  <= 1'b0;
         load_ready   <= 1'b1;
         load_done_o  <= 1'b0;
         load_err_o   <= 1'b0;
      end else begin
         // CPU leaves reset one edge after RUN is entered and re-enters it on the leaving edge.
         cpu_rst_n_o <= (state == RUN) && !reload_i;
         case (state)
            LOAD: begin
               if (accept) begin
                  if (full) begin
                     state      <= ERROR;
                     load_ready <= 1'b0;
                     load_err_o <= 1'b1;
                  end else if (wr_en) begin
                     byte_cnt     <= 2'd0;
                     word_count_o <= word_count_o + 1'b1;
                     if (load.load_last_i) begin
                        state       <= RUN;
                        load_ready  <= 1'b0;
                        load_done_o <= 1'b1;
                     end
                  end else begin
                     byte_cnt <= byte_cnt + 2'd1;
                  end
               end
            end
            RUN: begin
               if (reload_i) begin
                  state        <= LOAD;
                  load_ready   <= 1'b1;
                  load_done_o  <= 1'b0;
                  byte_cnt     <= 2'd0;
                  word_count_o <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // RAM and partial-word storage are not reset; stale data is masked by word_count_o.
   always_ff @(posedge clk) begin
      if (accept && !full) part_word <= asm_word[23:0];
      if (wr_en) ram[word_count_o[IDX_W-1:0]] <= DAT_WIDTH'(asm_word);
   end

   assign pc_word = pc_i >> 2;
   assign instr_o = (load_done_o && (pc_word < ADDR_WIDTH'(word_count_o)))
                    ? ram[pc_i[IDX_W+1:2]] : NOP;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: byte-stream loads scored against a word-assembly model.
module tb_instr_mem_loader;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int WCW   = $clog2(DEPTH) + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           reload_i = 1'b0;
   logic [AW-1:0]  pc_i = '0;
   logic [DW-1:0]  instr_o;
   logic           cpu_rst_n_o;
   logic           load_done_o;
   logic           load_err_o;
   logic [WCW-1:0] word_count_o;

   instr_mem_loader_if lif ();

   instr_mem_loader #(
      .ADDR_WIDTH (AW),
      .DAT_WIDTH  (DW),
      .DEPTH_WORDS(DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (lif),
      .reload_i    (reload_i),
      .pc_i        (pc_i),
      .instr_o     (instr_o),
      .cpu_rst_n_o (cpu_rst_n_o),
      .load_done_o (load_done_o),
      .load_err_o  (load_err_o),
      .word_count_o(word_count_o)
   );

   always #5 clk = ~clk;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic [AW-1:0] pc;
      logic [DW-1:0] exp;
   } vec_t;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_q[$];
   logic [31:0] m_word = 32'h0;
   int          m_cnt = 0;
   vec_t        vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; the byte is presented for exactly one rising edge.
   task automatic send_byte(input logic [7:0] d, input logic last, input bit model);
      lif.load_valid_i = 1'b1;
      lif.load_data_i  = d;
      lif.load_last_i  = last;
      @(negedge clk);
      if (model) begin
         m_word = m_word | (32'(d) << (8 * m_cnt));
         m_cnt++;
         if (m_cnt == 4 || last) begin
            exp_q.push_back(m_word);
            m_word = 32'h0;
            m_cnt  = 0;
         end
      end
   endtask

   task automatic idle(input int n);
      lif.load_valid_i = 1'b0;
      lif.load_last_i  = 1'b0;
      lif.load_data_i  = 8'($urandom);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_image(input bq_t b, input bit with_last, input int gap);
      for (int i = 0; i < b.size(); i++) begin
         send_byte(b[i], with_last && (i == b.size() - 1), 1'b1);
         if (gap > 0) idle(gap);
      end
      idle(0);
   endtask

   task automatic verify_image(input string name);
      int n = exp_q.size();
      int i = 0;
      check({name, " word_count"}, 32'(word_count_o), 32'(n));
      while (exp_q.size() > 0) begin
         pc_i = AW'(4 * i) + AW'($urandom_range(0, 3));
         #1;
         check({name, " instr"}, instr_o, exp_q.pop_front());
         i++;
      end
      pc_i = AW'(4 * n);
      #1;
      check({name, " past end"}, instr_o, NOP);
   endtask

   task automatic pulse_reload();
      reload_i = 1'b1;
      @(negedge clk);
      reload_i = 1'b0;
   endtask

   task automatic reset_mid_cycle();
      #2 rst_n = 1'b0;
      #1;
      m_word = 32'h0;
      m_cnt  = 0;
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t b;
      lif.load_valid_i = 1'b0;
      lif.load_data_i  = 8'h0;
      lif.load_last_i  = 1'b0;

      vecs[0] = '{32'h0000_0000, 32'h0050_0513};
      vecs[1] = '{32'h0000_0004, 32'h00A0_0593};
      vecs[2] = '{32'h0000_0008, NOP};
      vecs[3] = '{32'h0000_0007, 32'h00A0_0593};
      vecs[4] = '{32'h0000_0001, 32'h0050_0513};
      vecs[5] = '{32'h0000_000C, NOP};
      vecs[6] = '{32'h0000_0010, NOP};
      vecs[7] = '{32'hFFFF_FFFC, NOP};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst cpu_rst_n", 32'(cpu_rst_n_o), 32'd0);
      check("rst load_done", 32'(load_done_o), 32'd0);
      check("rst load_err", 32'(load_err_o), 32'd0);
      check("rst word_count", 32'(word_count_o), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst load_ready", 32'(lif.load_ready_o), 32'd1);
      #1 check("rst instr", instr_o, NOP);

      // Two-word image, back to back
      b = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
      load_image(b, 1'b1, 0);
      check("img1 load_done", 32'(load_done_o), 32'd1);
      check("img1 cpu_rst_n early", 32'(cpu_rst_n_o), 32'd0);
      check("img1 load_ready", 32'(lif.load_ready_o), 32'd0);
      @(negedge clk);
      check("img1 cpu_rst_n", 32'(cpu_rst_n_o), 32'd1);
      for (int i = 0; i < 8; i++) begin
         pc_i = vecs[i].pc;
         #1;
         check($sformatf("img1 vec%0d", i), instr_o, vecs[i].exp);
      end
      verify_image("img1");

      // Reload from RUN
      @(negedge clk);
      pulse_reload();
      check("reload cpu_rst_n", 32'(cpu_rst_n_o), 32'd0);
      check("reload load_ready", 32'(lif.load_ready_o), 32'd1);
      check("reload word_count", 32'(word_count_o), 32'd0);
      check("reload load_done", 32'(load_done_o), 32'd0);
      pc_i = 32'h0;
      #1 check("reload instr pc0", instr_o, NOP);
      pc_i = 32'h4;
      #1 check("reload instr pc4", instr_o, NOP);

      // Short partial image
      @(negedge clk);
      b = '{8'h37, 8'h12};
      load_image(b, 1'b1, 0);
      check("short load_done", 32'(load_done_o), 32'd1);
      verify_image("short");

      // Gapped valid gives the same image
      @(negedge clk);
      pulse_reload();
      b = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
      load_image(b, 1'b1, 1);
      check("gap load_done", 32'(load_done_o), 32'd1);
      verify_image("gap");

      // Reset in the middle of a word discards the partial bytes
      @(negedge clk);
      pulse_reload();
      send_byte(8'h11, 1'b0, 1'b0);
      send_byte(8'h22, 1'b0, 1'b0);
      idle(0);
      reset_mid_cycle();
      check("midword rst word_count", 32'(word_count_o), 32'd0);
      check("midword rst cpu_rst_n", 32'(cpu_rst_n_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      load_image(b, 1'b1, 0);
      verify_image("midword");
      @(negedge clk);
      check("midword cpu_rst_n", 32'(cpu_rst_n_o), 32'd1);

      // Reset during RUN holds the CPU until a new image arrives
      reset_mid_cycle();
      check("runrst cpu_rst_n", 32'(cpu_rst_n_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("runrst cpu_rst_n held", 32'(cpu_rst_n_o), 32'd0);
      check("runrst load_ready", 32'(lif.load_ready_o), 32'd1);
      pc_i = 32'h0;
      #1 check("runrst instr", instr_o, NOP);

      // Overflow: 17 bytes into a 4-word RAM
      @(negedge clk);
      for (int i = 0; i < 16; i++) send_byte(8'(i + 1), 1'b0, 1'b1);
      idle(0);
      check("ovf word_count", 32'(word_count_o), 32'd4);
      check("ovf err before", 32'(load_err_o), 32'd0);
      check("ovf ready before", 32'(lif.load_ready_o), 32'd1);
      send_byte(8'hEE, 1'b0, 1'b0);
      idle(0);
      check("ovf load_err", 32'(load_err_o), 32'd1);
      check("ovf load_ready", 32'(lif.load_ready_o), 32'd0);
      check("ovf cpu_rst_n", 32'(cpu_rst_n_o), 32'd0);
      check("ovf load_done", 32'(load_done_o), 32'd0);
      check("ovf word_count after", 32'(word_count_o), 32'd4);
      pulse_reload();
      @(negedge clk);
      check("ovf reload ignored err", 32'(load_err_o), 32'd1);
      check("ovf reload ignored ready", 32'(lif.load_ready_o), 32'd0);
      exp_q.delete();

      // Exactly DEPTH words with last on the final byte is legal
      reset_mid_cycle();
      check("full rst load_err", 32'(load_err_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h12, 8'h13, 8'h14,
            8'h21, 8'h22, 8'h23, 8'h24, 8'h31, 8'h32, 8'h33, 8'h34};
      load_image(b, 1'b1, 0);
      check("full load_done", 32'(load_done_o), 32'd1);
      check("full load_err", 32'(load_err_o), 32'd0);
      verify_image("full");

      // Short last word after reload: upper lanes zero over stale RAM
      @(negedge clk);
      pulse_reload();
      b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB5};
      load_image(b, 1'b1, 0);
      verify_image("pad");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, is the PC width.
REQ-002 Parameter DAT_WIDTH, default 32, is the instruction word width.
REQ-003 Parameter DEPTH_WORDS, default 256, is the power-of-two instruction RAM depth in words.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low; ports clk and rst_n.
REQ-005 Port clk  input  1  rising-edge clock.
REQ-006 Port rst_n  input  1  asynchronous active-low reset.
REQ-007 Port load_valid_i  input  1  load byte valid.
REQ-008 Port load_data_i  input  8  load byte, little-endian within word.
REQ-009 Port load_last_i  input  1  final byte of image, qualified by load_valid_i.
REQ-010 Port load_ready_o  output  1  loader accepts a byte.
REQ-011 Port reload_i  input  1  single-cycle request to restart loading.
REQ-012 Port pc_i  input  ADDR_WIDTH  CPU fetch address (byte address).
REQ-013 Port instr_o  output  DAT_WIDTH  instruction for pc_i.
REQ-014 Port cpu_rst_n_o  output  1  active-low reset to the CPU core.
REQ-015 Port load_done_o  output  1  image loaded, CPU running.
REQ-016 Port load_err_o  output  1  overflow error, sticky.
REQ-017 Port word_count_o  output  log2(DEPTH_WORDS)+1  words written.

Function
REQ-018 The FSM SHALL have states LOAD, RUN, ERROR; LOAD after reset.
REQ-019 load_ready_o SHALL be 1 only in LOAD; a byte is accepted when load_valid_i and load_ready_o are both 1 at a rising edge.
REQ-020 Accepted bytes SHALL fill lanes [7:0],[15:8],[23:16],[31:24] in order via a 2-bit byte counter.
REQ-021 On the 4th accepted byte the assembled word SHALL be written to RAM[word_count] at that edge, word_count increments, byte counter wraps to 0.
REQ-022 An accepted byte with load_last_i=1 SHALL write the current word (unfilled upper lanes zero) if at least one byte is pending, and move to RUN at the same edge.
REQ-023 A byte accepted when word_count == DEPTH_WORDS SHALL be dropped, and the FSM moves to ERROR.
REQ-024 Exactly DEPTH_WORDS full words followed by load_last_i on the final byte SHALL be legal and move to RUN.
REQ-025 In RUN and ERROR, load_ready_o=0 and no RAM writes occur.
REQ-026 load_done_o SHALL equal (state==RUN); load_err_o SHALL equal (state==ERROR); ERROR exits only by rst_n.
REQ-027 cpu_rst_n_o SHALL be a register set to 1 at the edge after state becomes RUN, cleared at the same edge the FSM leaves RUN.
REQ-028 reload_i=1 in RUN SHALL move to LOAD, clear word_count and byte counter; it is ignored in LOAD and ERROR.
REQ-029 instr_o SHALL be combinational: RAM[pc_i[log2(DEPTH_WORDS)+1:2]] when state==RUN and pc_i>>2 < word_count, else 0x00000013 (NOP).
REQ-030 pc_i[1:0] SHALL be ignored; pc_i >= 4*DEPTH_WORDS returns NOP.

Reset
REQ-031 rst_n low SHALL immediately force state LOAD, byte counter 0, word_count_o 0, cpu_rst_n_o 0, load_done_o 0, load_err_o 0, load_ready_o 1 once released.
REQ-032 RAM contents SHALL NOT be reset; stale contents are masked by REQ-029.
REQ-033 Reset asserted mid-word SHALL discard the partial word; reset mid-RUN SHALL hold the CPU in reset until a new image loads.

Verification
REQ-034 Load bytes 13,05,50,00,93,05,A0,00 (last on final) -> RAM[0]=0x00500513, RAM[1]=0x00A00593, word_count_o=2, load_done_o next cycle, cpu_rst_n_o one cycle later; pc_i=4 -> instr_o=0x00A00593; pc_i=8 -> 0x00000013.
REQ-035 Bytes 37,12 with last on 0x12 -> RAM[0]=0x00001237, word_count_o=1, RUN.
REQ-036 DEPTH_WORDS=4, send 17 bytes without last -> after 16th word_count_o=4, 17th byte sets load_err_o=1, load_ready_o=0, cpu_rst_n_o stays 0.
REQ-037 load_valid_i toggled every other cycle with gaps -> same RAM image as back-to-back; no byte accepted while load_valid_i=0.
REQ-038 In RUN pulse reload_i -> cpu_rst_n_o=0 and load_ready_o=1 next cycle, word_count_o=0, instr_o=NOP for all pc_i; new image then loads correctly.
REQ-039 Assert rst_n low after 2 bytes, release, load 4 bytes AA,BB,CC,DD with last -> RAM[0]=0xDDCCBBAA, word_count_o=1.
